// File: rtl/mult_acc_pipe_pkg.sv
// ---------------------------------------------------------------------------
// param_mult_acc
//   Shared constants and types for the mult_acc_pipe slice.
//   WIDTH_IN  : default operand width (A, B, C)
//   WIDTH_OUT : default result/accumulator width, at least 2*WIDTH_IN+1
//   ACC_MAX   : saturation value of the accumulator at the default width
//   mode_e    : decoding of the MODE input
// ---------------------------------------------------------------------------
package param_mult_acc;

  localparam int WIDTH_IN  = 8;
  localparam int WIDTH_OUT = 20;

  localparam logic [WIDTH_OUT-1:0] ACC_MAX = {WIDTH_OUT{1'b1}};

  typedef enum logic {
    MODE_DIRECT = 1'b0,  // DATA_OUT = A*B + C, accumulator untouched
    MODE_ACC    = 1'b1   // ACC = ACC + A*B + C (saturating), DATA_OUT = ACC
  } mode_e;

endpackage : param_mult_acc

// File: rtl/mult_acc_pipe_if.sv
// ---------------------------------------------------------------------------
// mult_acc_pipe_if
//   Sample/result bundle of the multiply-accumulate pipeline.
//   Inputs to the pipe : A, B, C (operands), VALID_IN, MODE, CLR
//   Outputs of the pipe: DATA_OUT (registered result), VALID_OUT (pulse),
//                        OVF (sticky saturation flag)
//   master : the sample source / result sink
//   slave  : the pipeline itself
// ---------------------------------------------------------------------------
interface mult_acc_pipe_if #(
  parameter int WIDTH_IN  = param_mult_acc::WIDTH_IN,
  parameter int WIDTH_OUT = param_mult_acc::WIDTH_OUT
);

  logic [WIDTH_IN-1:0]  A;
  logic [WIDTH_IN-1:0]  B;
  logic [WIDTH_IN-1:0]  C;
  logic                 VALID_IN;
  logic                 MODE;
  logic                 CLR;

  logic [WIDTH_OUT-1:0] DATA_OUT;
  logic                 VALID_OUT;
  logic                 OVF;

  modport master (
    output A, B, C, VALID_IN, MODE, CLR,
    input  DATA_OUT, VALID_OUT, OVF
  );

  modport slave (
    input  A, B, C, VALID_IN, MODE, CLR,
    output DATA_OUT, VALID_OUT, OVF
  );

endinterface : mult_acc_pipe_if

// File: rtl/mult_acc_pipe_mult_stage.sv
// ---------------------------------------------------------------------------
// mult_stage
//   First pipeline stage: registers the full-width product A*B and delays
//   C and the control bits alongside it so stage 2 sees one coherent sample.
//   Ports:
//     clk, reset         : clock, asynchronous active-high reset
//     valid_in, mode, clr: sample controls (payload captured only when valid)
//     a, b, c            : unsigned operands
//     prod_q             : registered a*b, 2*WIDTH_IN bits, never truncated
//     c_q                : registered addend
//     valid_q, mode_q,
//     clr_q              : registered controls
// ---------------------------------------------------------------------------
module mult_stage #(
  parameter int WIDTH_IN = param_mult_acc::WIDTH_IN
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  valid_in,
  input  logic                  mode,
  input  logic                  clr,
  input  logic [WIDTH_IN-1:0]   a,
  input  logic [WIDTH_IN-1:0]   b,
  input  logic [WIDTH_IN-1:0]   c,
  output logic [2*WIDTH_IN-1:0] prod_q,
  output logic [WIDTH_IN-1:0]   c_q,
  output logic                  valid_q,
  output logic                  mode_q,
  output logic                  clr_q
);

  localparam int PROD_W = 2 * WIDTH_IN;

  // NOTE: sequential state is written with <= so every register samples the
  // pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: only valid_q strictly needs a reset to kill in-flight samples;
      // the payload is reset too so the pipe comes up fully deterministic.
      prod_q  <= '0;
      c_q     <= '0;
      valid_q <= 1'b0;
      mode_q  <= 1'b0;
      clr_q   <= 1'b0;
    end else begin
      valid_q <= valid_in;
      // Payload only moves with a real sample; a bubble leaves it parked,
      // which is harmless because stage 2 ignores it when valid_q is 0.
      if (valid_in) begin
        prod_q <= PROD_W'(a) * PROD_W'(b);
        c_q    <= c;
        mode_q <= mode;
        clr_q  <= clr;
      end
    end
  end

endmodule : mult_stage

// File: rtl/mult_acc_pipe.sv
// ---------------------------------------------------------------------------
// mult_acc_pipe
//   Two-stage unsigned multiply-add / multiply-accumulate pipeline.
//   Stage 1 (mult_stage) registers A*B, C and the controls; stage 2 forms
//   A*B+C and either emits it directly (MODE=0) or adds it to a saturating
//   accumulator (MODE=1). One sample per clock, no back-pressure; a sample
//   driven into the pipe before edge n+1 is visible on DATA_OUT after n+2.
//   Ports:
//     clk   : clock, all state updates on the rising edge
//     reset : asynchronous active-high reset, clears every register
//     bus   : mult_acc_pipe_if.slave (A, B, C, VALID_IN, MODE, CLR in;
//             DATA_OUT, VALID_OUT, OVF out)
//   WIDTH_OUT must be at least 2*WIDTH_IN+1 so A*B+C always fits.
// ---------------------------------------------------------------------------
module mult_acc_pipe #(
  parameter int WIDTH_IN  = param_mult_acc::WIDTH_IN,
  parameter int WIDTH_OUT = param_mult_acc::WIDTH_OUT
) (
  input  logic              clk,
  input  logic              reset,
  mult_acc_pipe_if.slave    bus
);

  import param_mult_acc::*;

  localparam int PROD_W = 2 * WIDTH_IN;
  localparam logic [WIDTH_OUT-1:0] SAT_MAX = {WIDTH_OUT{1'b1}};

  // -------------------------------------------------------------------------
  // Stage 1
  // -------------------------------------------------------------------------
  logic [PROD_W-1:0]   prod_q;
  logic [WIDTH_IN-1:0] c_q;
  logic                valid_q;
  logic                mode_q;
  logic                clr_q;

  mult_stage #(
    .WIDTH_IN (WIDTH_IN)
  ) u_mult_stage (
    .clk      (clk),
    .reset    (reset),
    .valid_in (bus.VALID_IN),
    .mode     (bus.MODE),
    .clr      (bus.CLR),
    .a        (bus.A),
    .b        (bus.B),
    .c        (bus.C),
    .prod_q   (prod_q),
    .c_q      (c_q),
    .valid_q  (valid_q),
    .mode_q   (mode_q),
    .clr_q    (clr_q)
  );

  // -------------------------------------------------------------------------
  // Stage 2: add, accumulate, saturate
  // -------------------------------------------------------------------------
  logic [WIDTH_OUT-1:0] acc_q;
  logic [WIDTH_OUT-1:0] data_q;
  logic                 valid_out_q;
  logic                 ovf_q;

  logic [WIDTH_OUT-1:0] term;  // A*B + C, cannot overflow WIDTH_OUT
  logic [WIDTH_OUT-1:0] base;  // accumulator seen by this sample
  logic [WIDTH_OUT:0]   sum;   // one carry bit to detect saturation
  logic                 sat;

  // NOTE: every always_comb output is given a value up front so no path
  // through the block can leave it unassigned and infer a latch.
  always_comb begin
    term = '0;
    base = '0;
    sum  = '0;
    sat  = 1'b0;

    term = WIDTH_OUT'(prod_q) + WIDTH_OUT'(c_q);
    // CLR restarts the running sum with this very sample, not the next one.
    base = clr_q ? '0 : acc_q;
    sum  = {1'b0, base} + {1'b0, term};
    sat  = sum[WIDTH_OUT];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_q       <= '0;
      data_q      <= '0;
      valid_out_q <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      valid_out_q <= valid_q;
      if (valid_q) begin
        if (mode_q == MODE_ACC) begin
          if (sat) begin
            acc_q  <= SAT_MAX;
            data_q <= SAT_MAX;
            ovf_q  <= 1'b1;
          end else begin
            acc_q  <= sum[WIDTH_OUT-1:0];
            data_q <= sum[WIDTH_OUT-1:0];
            // A clean restart drops the sticky flag; otherwise it holds.
            if (clr_q) begin
              ovf_q <= 1'b0;
            end
          end
        end else begin
          // Direct mode leaves the running sum alone unless told to clear it.
          data_q <= term;
          if (clr_q) begin
            acc_q <= '0;
            ovf_q <= 1'b0;
          end
        end
      end
    end
  end

  assign bus.DATA_OUT  = data_q;
  assign bus.VALID_OUT = valid_out_q;
  assign bus.OVF       = ovf_q;

endmodule : mult_acc_pipe

// File: tb/tb_mult_acc_pipe.sv
// ---------------------------------------------------------------------------
// tb_mult_acc_pipe
//   Directed bench for mult_acc_pipe at WIDTH_IN=8, WIDTH_OUT=20.
//   Inputs are applied on the falling edge, so a sample applied at falling
//   edge k is captured by stage 1 at the next rising edge and its result is
//   read back at falling edge k+2 (two rising edges later).
// ---------------------------------------------------------------------------
module tb_mult_acc_pipe;

  import param_mult_acc::*;

  logic clk;
  logic reset;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  mult_acc_pipe_if #(
    .WIDTH_IN  (WIDTH_IN),
    .WIDTH_OUT (WIDTH_OUT)
  ) bus ();

  mult_acc_pipe #(
    .WIDTH_IN  (WIDTH_IN),
    .WIDTH_OUT (WIDTH_OUT)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic expect_out(input string tag, input logic v,
                            input logic [31:0] d, input logic o);
    check({tag, "/valid"}, 32'(bus.VALID_OUT), 32'(v));
    check({tag, "/data"},  32'(bus.DATA_OUT),  d);
    check({tag, "/ovf"},   32'(bus.OVF),       32'(o));
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic drive(input logic [WIDTH_IN-1:0] a, b, c,
                       input logic mode, clr);
    bus.A        = a;
    bus.B        = b;
    bus.C        = c;
    bus.MODE     = mode;
    bus.CLR      = clr;
    bus.VALID_IN = 1'b1;
  endtask

  // Invalid cycle carrying garbage payload and CLR=1, all of which must be
  // ignored by the pipe.
  task automatic bubble();
    bus.A        = '1;
    bus.B        = '1;
    bus.C        = '1;
    bus.MODE     = 1'b1;
    bus.CLR      = 1'b1;
    bus.VALID_IN = 1'b0;
  endtask

  initial begin
    reset        = 1'b1;
    bus.A        = '0;
    bus.B        = '0;
    bus.C        = '0;
    bus.MODE     = 1'b0;
    bus.CLR      = 1'b0;
    bus.VALID_IN = 1'b0;

    // ---------------- reset state ----------------
    tick();
    tick();
    expect_out("reset", 1'b0, 0, 1'b0);
    reset = 1'b0;

    // ---------------- basic: 3*4+5 = 17 ----------------
    tick(); drive(3, 4, 5, 1'b0, 1'b0);
    tick(); expect_out("basic_early", 1'b0, 0, 1'b0);  bubble();
    tick(); expect_out("basic", 1'b1, 17, 1'b0);       bubble();
    tick(); expect_out("basic_pulse", 1'b0, 17, 1'b0);

    // ---------------- streaming, MODE=0 ----------------
    tick(); drive(1, 1, 1, 1'b0, 1'b0);
    tick(); drive(2, 3, 4, 1'b0, 1'b0);
    tick(); expect_out("stream0", 1'b1, 2, 1'b0);      drive(255, 255, 255, 1'b0, 1'b0);
    tick(); expect_out("stream1", 1'b1, 10, 1'b0);     bubble();
    tick(); expect_out("stream2", 1'b1, 65280, 1'b0);  bubble();
    tick(); expect_out("stream_end", 1'b0, 65280, 1'b0);

    // ---------------- accumulate with clear, bubbles ----------------
    tick(); drive(10, 10, 0, 1'b1, 1'b1);
    tick(); bubble();
    tick(); expect_out("acc_clr", 1'b1, 100, 1'b0);    drive(1, 2, 3, 1'b1, 1'b0);
    tick(); bubble();
    tick(); expect_out("acc_add", 1'b1, 105, 1'b0);    bubble();
    tick(); expect_out("acc_hold", 1'b0, 105, 1'b0);   drive(0, 0, 1, 1'b1, 1'b0);
    tick(); bubble();
    tick(); expect_out("acc_after_bubble", 1'b1, 106, 1'b0);

    // ---------------- saturation: 17 x 65280 ----------------
    for (int i = 0; i <= 16; i++) begin
      tick();
      if (i >= 2) expect_out($sformatf("sat_run%0d", i - 2), 1'b1, (i - 1) * 65280, 1'b0);
      drive(255, 255, 255, 1'b1, (i == 0));
    end
    tick(); expect_out("sat_16th", 1'b1, 1044480, 1'b0);  drive(0, 0, 0, 1'b1, 1'b0);
    tick(); expect_out("sat_17th", 1'b1, 1048575, 1'b1);  drive(2, 2, 2, 1'b0, 1'b0);
    tick(); expect_out("sat_sticky", 1'b1, 1048575, 1'b1); drive(1, 1, 0, 1'b1, 1'b1);
    tick(); expect_out("sat_direct", 1'b1, 6, 1'b1);      bubble();
    tick(); expect_out("sat_clr", 1'b1, 1, 1'b0);         bubble();
    tick(); expect_out("sat_idle", 1'b0, 1, 1'b0);

    // ---------------- mixed modes, CLR with MODE=0 ----------------
    tick(); drive(2, 2, 0, 1'b1, 1'b1);
    tick(); drive(9, 9, 9, 1'b0, 1'b0);
    tick(); expect_out("mix_acc0", 1'b1, 4, 1'b0);    drive(1, 1, 0, 1'b1, 1'b0);
    tick(); expect_out("mix_direct", 1'b1, 90, 1'b0); drive(3, 3, 0, 1'b0, 1'b1);
    tick(); expect_out("mix_acc1", 1'b1, 5, 1'b0);    drive(0, 0, 7, 1'b1, 1'b0);
    tick(); expect_out("dclr_data", 1'b1, 9, 1'b0);   bubble();
    tick(); expect_out("dclr_acc", 1'b1, 7, 1'b0);    bubble();
    tick(); expect_out("mix_idle", 1'b0, 7, 1'b0);

    // ---------------- reset mid-stream ----------------
    tick(); drive(5, 5, 5, 1'b1, 1'b1);
    tick(); drive(6, 6, 6, 1'b0, 1'b0);
    tick(); expect_out("pre_rst", 1'b1, 30, 1'b0);    drive(7, 7, 7, 1'b0, 1'b0);
    #2 reset = 1'b1;
    #1 expect_out("rst_async", 1'b0, 0, 1'b0);
    tick(); expect_out("rst_held", 1'b0, 0, 1'b0);
    tick(); reset = 1'b0; bubble();
    for (int i = 0; i < 3; i++) begin
      tick(); expect_out($sformatf("rst_flush%0d", i), 1'b0, 0, 1'b0);
    end
    tick(); drive(4, 4, 4, 1'b0, 1'b0);
    tick(); bubble();
    tick(); expect_out("post_rst", 1'b1, 20, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule : tb_mult_acc_pipe
